// File: rtl/protobuf_stream_drainer.sv
// Drains the serializer output FIFO with fixed-address byte-beat AXI read bursts into a local byte FIFO.
// Latency: issue decision->arvalid 1 cycle, AR handshake->rready 1 cycle, R beat->aso_out_valid 1 cycle.
// Backpressure: a burst is issued only when it fits locally, so rready never stalls; aso_out_ready only slows draining.
module protobuf_stream_drainer #(
   parameter int          BURST_LEN  = 8,
   parameter int          FIFO_DEPTH = 16,
   parameter logic [3:0]  AR_ID      = 4'b0000,
   parameter logic [31:0] SRC_ADDR   = 32'h0000_0000
) (
   input  logic        clock_clk,
   input  logic        reset_reset_n,
   input  logic        enable,
   input  logic [13:0] of_usedw,
   output logic [3:0]  axm_m0_arid,
   output logic [31:0] axm_m0_araddr,
   output logic [7:0]  axm_m0_arlen,
   output logic [2:0]  axm_m0_arsize,
   output logic [1:0]  axm_m0_arburst,
   output logic        axm_m0_arvalid,
   input  logic        axm_m0_arready,
   input  logic [3:0]  axm_m0_rid,
   input  logic [31:0] axm_m0_rdata,
   input  logic        axm_m0_rlast,
   input  logic        axm_m0_rvalid,
   output logic        axm_m0_rready,
   output logic [7:0]  aso_out_data,
   output logic        aso_out_valid,
   input  logic        aso_out_ready,
   output logic        err,
   output logic [31:0] bytes_out
);

   localparam int BW = $clog2(BURST_LEN) + 1;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ADDR = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;

   localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
   localparam logic [13:0]   USEDW_MIN = 14'(BURST_LEN);
   // Highest local fill level that still leaves room for a whole burst.
   localparam logic [CW-1:0] ROOM_MAX  = CW'(FIFO_DEPTH - BURST_LEN);

   logic [1:0]    state_q, state_d;
   logic          arvalid_q, arvalid_d;
   logic          rready_q, rready_d;
   logic [BW-1:0] beat_cnt_q, beat_cnt_d;
   logic          err_q, err_d;
   logic [31:0]   bytes_out_q, bytes_out_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [7:0]    mem_d [FIFO_DEPTH];

   logic beat;
   logic last_beat;
   logic pop;
   logic unused_rdata_hi;

   // Only the low byte of each read beat carries stream data.
   assign unused_rdata_hi = ^axm_m0_rdata[31:8];

   assign beat      = rready_q & axm_m0_rvalid;
   assign last_beat = (beat_cnt_q == LAST_BEAT);
   assign pop       = aso_out_valid & aso_out_ready;

   assign axm_m0_arid    = AR_ID;
   assign axm_m0_araddr  = SRC_ADDR;
   assign axm_m0_arlen   = 8'(BURST_LEN - 1);
   assign axm_m0_arsize  = 3'b000;
   assign axm_m0_arburst = 2'b00;
   assign axm_m0_arvalid = arvalid_q;
   assign axm_m0_rready  = rready_q;
   assign aso_out_valid  = (count_q != '0);
   assign aso_out_data   = aso_out_valid ? mem_q[rd_ptr_q] : 8'h00;
   assign err            = err_q;
   assign bytes_out      = bytes_out_q;

   // Burst sequencing and sticky protocol checking; errors never alter data flow.
   always_comb begin
      state_d    = state_q;
      arvalid_d  = arvalid_q;
      rready_d   = rready_q;
      beat_cnt_d = beat_cnt_q;
      err_d      = err_q;
      case (state_q)
         ST_IDLE: begin
            // Same-cycle pop is ignored, so the room test is conservative.
            if (enable && (of_usedw >= USEDW_MIN) && (count_q <= ROOM_MAX)) begin
               state_d   = ST_ADDR;
               arvalid_d = 1'b1;
            end
         end
         ST_ADDR: begin
            if (arvalid_q && axm_m0_arready) begin
               state_d   = ST_DATA;
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
            end
         end
         ST_DATA: begin
            if (beat) begin
               beat_cnt_d = beat_cnt_q + 1'b1;
               if (axm_m0_rid != AR_ID) err_d = 1'b1;
               if (axm_m0_rlast != last_beat) err_d = 1'b1;
               if (last_beat) begin
                  state_d    = ST_IDLE;
                  rready_d   = 1'b0;
                  beat_cnt_d = '0;
               end
            end
         end
         default: begin
            state_d    = ST_IDLE;
            arvalid_d  = 1'b0;
            rready_d   = 1'b0;
            beat_cnt_d = '0;
         end
      endcase
      // Read data with no burst outstanding is a slave protocol violation.
      if (axm_m0_rvalid && (state_q != ST_DATA)) err_d = 1'b1;
   end

   // Local byte FIFO bookkeeping and output handshake counter.
   always_comb begin
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      bytes_out_d = bytes_out_q;
      if (beat) begin
         mem_d[wr_ptr_q] = axm_m0_rdata[7:0];
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d    = rd_ptr_q + 1'b1;
         bytes_out_d = bytes_out_q + 32'd1;
      end
      case ({beat, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Control and FIFO pointer state with synchronous active-low reset.
   always_ff @(posedge clock_clk) begin
      if (!reset_reset_n) begin
         state_q     <= ST_IDLE;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         beat_cnt_q  <= '0;
         err_q       <= 1'b0;
         bytes_out_q <= 32'd0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         beat_cnt_q  <= beat_cnt_d;
         err_q       <= err_d;
         bytes_out_q <= bytes_out_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
      end
   end

   // Storage array needs no reset: the output is masked while the FIFO is empty.
   always_ff @(posedge clock_clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: tb/tb_protobuf_stream_drainer.sv
// Directed bench for protobuf_stream_drainer with a scripted AXI read slave.
// Expected bytes come from the stimulus data; expected counts and flags are hand-derived.
// Output ready is either driven directly or randomised for the long streaming run.
module tb_protobuf_stream_drainer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic [13:0] usedw = 14'd0;
   logic        arready = 1'b0;
   logic [3:0]  rid = 4'h0;
   logic [31:0] rdata = 32'h0;
   logic        rlast = 1'b0;
   logic        rvalid = 1'b0;
   logic        out_ready = 1'b0;
   logic        rand_rdy = 1'b0;
   logic        rdy_rand = 1'b0;
   logic        dut_ready;

   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        rready;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        err;
   logic [31:0] bytes_out;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          exp_bytes = 0;
   int          ar_cnt = 0;
   logic [7:0]  ar_len_seen = 8'hFF;
   logic [2:0]  ar_size_seen = 3'h7;
   logic [1:0]  ar_burst_seen = 2'h3;
   logic [7:0]  exp_q[$];
   logic [7:0]  got_q[$];

   assign dut_ready = rand_rdy ? rdy_rand : out_ready;

   protobuf_stream_drainer dut (
      .clock_clk      (clk),
      .reset_reset_n  (rst_n),
      .enable         (enable),
      .of_usedw       (usedw),
      .axm_m0_arid    (arid),
      .axm_m0_araddr  (araddr),
      .axm_m0_arlen   (arlen),
      .axm_m0_arsize  (arsize),
      .axm_m0_arburst (arburst),
      .axm_m0_arvalid (arvalid),
      .axm_m0_arready (arready),
      .axm_m0_rid     (rid),
      .axm_m0_rdata   (rdata),
      .axm_m0_rlast   (rlast),
      .axm_m0_rvalid  (rvalid),
      .axm_m0_rready  (rready),
      .aso_out_data   (out_data),
      .aso_out_valid  (out_valid),
      .aso_out_ready  (dut_ready),
      .err            (err),
      .bytes_out      (bytes_out)
   );

   always #5 clk = ~clk;

   // Randomised consumer ready, roughly 75% duty.
   always @(negedge clk) begin
      rdy_rand <= ($urandom_range(0, 3) != 0);
   end

   // Capture stream handshakes and AR handshakes.
   always @(posedge clk) begin
      if (rst_n && out_valid && dut_ready) got_q.push_back(out_data);
      if (rst_n && arvalid && arready) begin
         ar_cnt        <= ar_cnt + 1;
         ar_len_seen   <= arlen;
         ar_size_seen  <= arsize;
         ar_burst_seen <= arburst;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Scripted slave: wait for AR, accept it, then return nbeats beats (low byte first).
   task automatic burst(input logic [63:0] dat, input int nbeats, input logic [7:0] last_mask,
                        input logic [3:0] id, input logic [13:0] usedw_after, input logic en_after,
                        output logic rr_end);
      int n;
      n = 0;
      rr_end = 1'bx;
      while (!arvalid && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("ar_wait", {31'd0, arvalid}, 32'd1);
      if (!arvalid) return;
      usedw   = usedw_after;
      arready = 1'b1;
      @(negedge clk);
      arready = 1'b0;
      enable  = en_after;
      check("rready_lat", {31'd0, rready}, 32'd1);
      for (int b = 0; b < nbeats; b++) begin
         n = 0;
         while (!rready && n < 20) begin
            @(negedge clk);
            n++;
         end
         rvalid = 1'b1;
         rdata  = {24'hABCDEF, dat[8*b +: 8]};
         rlast  = last_mask[b];
         rid    = id;
         exp_q.push_back(dat[8*b +: 8]);
         exp_bytes++;
         @(negedge clk);
      end
      rvalid = 1'b0;
      rlast  = 1'b0;
      rid    = 4'h0;
      rr_end = rready;
   endtask

   task automatic drain_and_compare(input string tag);
      int n;
      int bad;
      n   = 0;
      bad = 0;
      while (got_q.size() < exp_q.size() && n < 2000) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      check({tag, "_len"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         if (got_q[i] !== exp_q[i]) bad++;
      check({tag, "_bad_bytes"}, bad, 0);
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      exp_bytes = 0;
      got_q.delete();
      exp_q.delete();
   endtask

   // Bounded run time.
   initial begin
      repeat (200000) @(posedge clk);
      $display("FAIL watchdog: cycle budget exhausted, got %0d compared expected completion", n_cmp);
      $fatal(1, "watchdog");
   end

   initial begin
      logic rr;
      int   n_hi;
      int   base;
      logic [63:0] d;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_arvalid", {31'd0, arvalid}, 32'd0);
      check("rst_rready", {31'd0, rready}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data", {24'd0, out_data}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_bytes_out", bytes_out, 32'd0);
      check("const_arlen", {24'd0, arlen}, 32'd7);
      check("const_arsize", {29'd0, arsize}, 32'd0);
      check("const_arburst", {30'd0, arburst}, 32'd0);
      check("const_arid", {28'd0, arid}, 32'd0);
      check("const_araddr", araddr, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Insufficient data holds off the burst; reaching a full burst issues it one cycle later.
      enable = 1'b1;
      usedw = 14'd7;
      out_ready = 1'b1;
      n_hi = 0;
      repeat (100) begin
         @(negedge clk);
         if (arvalid) n_hi++;
      end
      check("short_usedw_ar_cycles", n_hi, 0);
      usedw = 14'd8;
      @(negedge clk);
      check("arvalid_lat", {31'd0, arvalid}, 32'd1);
      check("rready_before_hs", {31'd0, rready}, 32'd0);

      // Happy path: "Go Blue!"
      burst(64'h2165756C42206F47, 8, 8'h80, 4'h0, 14'd0, 1'b1, rr);
      check("happy_rready_end", {31'd0, rr}, 32'd0);
      check("happy_ar_cnt", ar_cnt, 1);
      check("happy_arlen", {24'd0, ar_len_seen}, 32'd7);
      check("happy_arsize", {29'd0, ar_size_seen}, 32'd0);
      check("happy_arburst", {30'd0, ar_burst_seen}, 32'd0);
      repeat (12) @(negedge clk);
      check("happy_first_byte", {24'd0, got_q.size() > 0 ? got_q[0] : 8'hXX}, 32'h47);
      check("happy_last_byte", {24'd0, got_q.size() > 7 ? got_q[7] : 8'hXX}, 32'h21);
      drain_and_compare("happy");
      check("happy_bytes_out", bytes_out, 32'd8);
      check("happy_err", {31'd0, err}, 32'd0);

      // Backpressure: two bursts fill the FIFO, then no more until it drains.
      out_ready = 1'b0;
      usedw = 14'd8192;
      base = ar_cnt;
      burst(64'h0807060504030201, 8, 8'h80, 4'h0, 14'd8192, 1'b1, rr);
      burst(64'h1817161514131211, 8, 8'h80, 4'h0, 14'd8192, 1'b1, rr);
      n_hi = 0;
      repeat (30) begin
         @(negedge clk);
         if (arvalid) n_hi++;
      end
      check("full_no_ar_cycles", n_hi, 0);
      check("full_two_bursts", ar_cnt - base, 2);
      check("full_out_valid", {31'd0, out_valid}, 32'd1);
      check("full_head_byte", {24'd0, out_data}, 32'h01);
      out_ready = 1'b1;
      burst(64'h2827262524232221, 8, 8'h80, 4'h0, 14'd0, 1'b1, rr);
      check("third_burst", ar_cnt - base, 3);
      drain_and_compare("bp");
      check("bp_bytes_out", bytes_out, 32'd32);

      // Dropping enable after the AR handshake still completes the burst.
      usedw = 14'd8192;
      burst(64'hA1B2C3D4E5F60718, 8, 8'h80, 4'h0, 14'd8192, 1'b0, rr);
      check("en_drop_rready_end", {31'd0, rr}, 32'd0);
      n_hi = 0;
      repeat (20) begin
         @(negedge clk);
         if (arvalid) n_hi++;
      end
      check("en_drop_no_new_ar", n_hi, 0);
      drain_and_compare("en_drop");
      check("en_drop_bytes_out", bytes_out, 32'd40);

      // Long random stream with random consumer ready.
      rand_rdy = 1'b1;
      enable = 1'b1;
      usedw = 14'd8192;
      for (int k = 0; k < 1250; k++) begin
         d = {$urandom, $urandom};
         burst(d, 8, 8'h80, 4'h0, (k == 1249) ? 14'd0 : 14'd8192, 1'b1, rr);
      end
      rand_rdy = 1'b0;
      out_ready = 1'b1;
      drain_and_compare("rand");
      check("rand_bytes_out", bytes_out, exp_bytes);
      check("rand_err", {31'd0, err}, 32'd0);

      // rlast on beat 5 flags an error but the burst still runs to 8 beats.
      usedw = 14'd8;
      burst(64'h5555AAAA33CC0FF0, 8, 8'h10, 4'h0, 14'd0, 1'b1, rr);
      check("rlast_err", {31'd0, err}, 32'd1);
      check("rlast_burst_end", {31'd0, rr}, 32'd0);
      drain_and_compare("rlast");
      pulse_reset();
      check("err_cleared_by_reset", {31'd0, err}, 32'd0);

      // Wrong RID flags an error that stays set.
      usedw = 14'd8;
      burst(64'h0123456789ABCDEF, 8, 8'h80, 4'h1, 14'd0, 1'b1, rr);
      check("rid_err", {31'd0, err}, 32'd1);
      drain_and_compare("rid");
      repeat (50) @(negedge clk);
      check("rid_err_sticky", {31'd0, err}, 32'd1);
      check("rid_bytes_out", bytes_out, 32'd8);

      // Reset after beat 3 abandons the burst immediately.
      out_ready = 1'b0;
      usedw = 14'd8;
      burst(64'hDEADBEEFCAFEF00D, 3, 8'h00, 4'h0, 14'd0, 1'b1, rr);
      check("mid_rready_high", {31'd0, rready}, 32'd1);
      check("mid_out_valid", {31'd0, out_valid}, 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_arvalid", {31'd0, arvalid}, 32'd0);
      check("midrst_rready", {31'd0, rready}, 32'd0);
      check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_out_data", {24'd0, out_data}, 32'd0);
      check("midrst_err", {31'd0, err}, 32'd0);
      check("midrst_bytes_out", bytes_out, 32'd0);
      rst_n = 1'b1;
      exp_bytes = 0;
      got_q.delete();
      exp_q.delete();
      @(negedge clk);

      // A fresh burst after the abandoned one behaves normally.
      out_ready = 1'b1;
      usedw = 14'd8;
      burst(64'h1122334455667788, 8, 8'h80, 4'h0, 14'd0, 1'b1, rr);
      check("post_rst_rready_end", {31'd0, rr}, 32'd0);
      drain_and_compare("post_rst");
      check("post_rst_bytes_out", bytes_out, 32'd8);
      check("post_rst_err", {31'd0, err}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
